// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the multi-port register file.
// Defaults reproduce the classic 32 x 32-bit general-purpose register file.
package regfile_pkg;

   localparam int DEF_DATA_W = 32;
   localparam int DEF_DEPTH  = 32;
   localparam int DEF_ADDR_W = 5;
   localparam int ZERO_IDX   = 0;

   // Ceiling log2, evaluated at elaboration for parameter legality checks.
   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) result = i + 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One read port: one-hot index decode, AND-OR selection over the storage,
// write-to-read forwarding and an optional output capture register.
module regfile_read_port
   import regfile_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int DEPTH    = DEF_DEPTH,
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1,
   parameter int READ_REG = 0
) (
   input  logic              clock,
   input  logic              ctrl_reset,
   input  logic [DATA_W-1:0] entries [DEPTH],
   input  logic [ADDR_W-1:0] addr,
   input  logic              read_enable,
   input  logic              write_valid,
   input  logic [ADDR_W-1:0] write_addr,
   input  logic [DATA_W-1:0] write_data,
   output logic [DATA_W-1:0] read_data
);

   logic [DEPTH-1:0]  sel;
   logic [DATA_W-1:0] stored;
   logic [DATA_W-1:0] value;
   logic              hit;

   // Out-of-range and hardwired-zero indices leave sel empty, so they read 0.
   always_comb begin
      sel = '0;
      for (int i = 0; i < DEPTH; i++) begin
         sel[i] = (addr == ADDR_W'(i));
      end
      if (ZERO_REG != 0) sel[ZERO_IDX] = 1'b0;
   end

   always_comb begin
      stored = '0;
      for (int i = 0; i < DEPTH; i++) begin
         stored = stored | ({DATA_W{sel[i]}} & entries[i]);
      end
   end

   assign hit   = (BYPASS != 0) && write_valid && (write_addr == addr) && (|sel);
   assign value = hit ? write_data : stored;

   generate
      if (READ_REG != 0) begin : g_registered
         always_ff @(posedge clock) begin
            if (ctrl_reset) begin
               read_data <= '0;
            end else if (read_enable) begin
               read_data <= value;
            end
         end
      end else begin : g_combinational
         assign read_data = value;
      end
   endgenerate

   // Some inputs are idle in certain parameterisations.
   logic unused_ok;
   assign unused_ok = ^{clock, ctrl_reset, read_enable, write_addr, write_data};

endmodule

// File: rtl/regfile_multiport.sv
// General-purpose register file: DEPTH x DATA_W storage, one write port and
// NUM_RD independent read ports with optional zero register, bypass and read stage.
module regfile_multiport
   import regfile_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int DEPTH    = DEF_DEPTH,
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int NUM_RD   = 2,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1,
   parameter int READ_REG = 0
) (
   input  logic                     clock,
   input  logic                     ctrl_reset,
   input  logic                     ctrl_writeEnable,
   input  logic [ADDR_W-1:0]        ctrl_writeReg,
   input  logic [DATA_W-1:0]        data_writeReg,
   input  logic [NUM_RD*ADDR_W-1:0] ctrl_readReg,
   input  logic [NUM_RD-1:0]        ctrl_readEnable,
   output logic [NUM_RD*DATA_W-1:0] data_readReg
);

   generate
      if (DEPTH < 2 || clog2(DEPTH) > ADDR_W || NUM_RD < 1 || NUM_RD > 4) begin : g_bad_params
         $error("regfile_multiport: illegal DEPTH/ADDR_W/NUM_RD combination");
      end
   endgenerate

   logic [DATA_W-1:0] entries [DEPTH];
   logic [DEPTH-1:0]  wsel;
   logic              write_valid;

   // Decoded write select; indices past DEPTH or the zero register match nothing.
   always_comb begin
      wsel = '0;
      for (int i = 0; i < DEPTH; i++) begin
         wsel[i] = (ctrl_writeReg == ADDR_W'(i));
      end
      if (ZERO_REG != 0) wsel[ZERO_IDX] = 1'b0;
   end

   assign write_valid = ctrl_writeEnable && (|wsel);

   always_ff @(posedge clock) begin
      if (ctrl_reset) begin
         for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (write_valid && wsel[i]) entries[i] <= data_writeReg;
         end
      end
   end

   generate
      for (genvar p = 0; p < NUM_RD; p++) begin : g_port
         regfile_read_port #(
            .DATA_W  (DATA_W),
            .DEPTH   (DEPTH),
            .ADDR_W  (ADDR_W),
            .ZERO_REG(ZERO_REG),
            .BYPASS  (BYPASS),
            .READ_REG(READ_REG)
         ) u_port (
            .clock      (clock),
            .ctrl_reset (ctrl_reset),
            .entries    (entries),
            .addr       (ctrl_readReg[ADDR_W*p +: ADDR_W]),
            .read_enable(ctrl_readEnable[p]),
            .write_valid(write_valid),
            .write_addr (ctrl_writeReg),
            .write_data (data_writeReg),
            .read_data  (data_readReg[DATA_W*p +: DATA_W])
         );
      end
   endgenerate

endmodule
